alu_seq: RTL

Multi-cycle 32-bit ALU that executes the 4-bit operation codes produced by the ALU control decoder (AC) in the execute stage of the datapath. Logical, arithmetic and compare ops complete in a fixed two-edge latency. Shift-left-logical runs bit-serially, one bit per cycle, under a counter. A start/busy/done handshake lets the multicycle controller stall until the result is valid.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_core.sv | 50 +++++
 rtl/alu_seq.sv | 105 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle ALU and the ALU control decoder.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the multicycle controller (master) and alu_seq (slave).
// Handshake: start is sampled only on an edge where busy = 0; that edge accepts the request.
// busy stays high until the edge that raises done; done is a one-cycle pulse with result/flags valid.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             illegal;

  modport master (
    output start, op, a, b, shamt,
    input  busy, done, result, zero, ovf, illegal
  );

  modport slave (
    input  start, op, a, b, shamt,
    output busy, done, result, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_core.sv
// Combinational datapath for the single-step ops (AND/OR/ADD/SUB/SLT).
// SLL is handled bit-serially by alu_seq; any undefined code reports illegal with a zero result.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf,
  output logic             o_illegal
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;
  logic             w_sa;
  logic             w_sb;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_lt   = ($signed(i_a) < $signed(i_b));
  assign w_sa   = i_a[WIDTH-1];
  assign w_sb   = i_b[WIDTH-1];

  always_comb begin
    o_result  = '0;
    o_ovf     = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_ADD: begin
        o_result = w_sum;
        o_ovf    = (w_sa == w_sb) && (w_sum[WIDTH-1] != w_sa);
      end
      OP_SUB: begin
        o_result = w_diff;
        o_ovf    = (w_sa != w_sb) && (w_diff[WIDTH-1] != w_sa);
      end
      OP_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
      // SLL never reaches this block through EXEC; report a neutral zero
      OP_SLL: o_result = '0;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: two-edge latency for logic/arith/compare ops, one bit per cycle for SLL.
// All outputs are registered; o_dbg_state exposes the FSM state.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output state_t     o_dbg_state
);

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;
  logic             r_done;

  logic [WIDTH-1:0] w_core_result;
  logic             w_core_ovf;
  logic             w_core_illegal;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op      (r_op),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_result  (w_core_result),
    .o_ovf     (w_core_ovf),
    .o_illegal (w_core_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op <= bus.op;
            r_a  <= bus.a;
            r_b  <= bus.b;
            if (bus.op == OP_SLL) begin
              r_acc   <= bus.b;
              r_cnt   <= bus.shamt;
              r_state <= SHIFT;
            end else begin
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          r_result  <= w_core_result;
          r_zero    <= (w_core_result == '0);
          r_ovf     <= w_core_ovf;
          r_illegal <= w_core_illegal;
          r_done    <= 1'b1;
          r_state   <= IDLE;
        end
        SHIFT: begin
          // cnt == 0 is checked before shifting, so shamt = 0 finishes like EXEC
          if (r_cnt == '0) begin
            r_result  <= r_acc;
            r_zero    <= (r_acc == '0);
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_acc <= {r_acc[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - SHW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.zero    = r_zero;
  assign bus.ovf     = r_ovf;
  assign bus.illegal = r_illegal;
  assign o_dbg_state = r_state;

endmodule
